// File: rtl/arith_pkg.sv
// Shared definitions for the small bit-serial arithmetic cells.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock through
// a single full_subtractor cell with a registered borrow.
//
//  state | meaning
//  IDLE  | waiting for start; operands captured on the accepting edge
//  RUN   | one bit per edge through the cell, WIDTH edges in total
//  DONE  | one-cycle done pulse; diff/borrow valid
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    import arith_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range 1..32");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_sh_nxt;
    logic             br;
    logic [CW-1:0]    bcnt;
    logic             cell_d;
    logic             cell_bo;
    logic             last;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .diff (cell_d),
        .bout (cell_bo)
    );

    // New bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
    assign d_sh_nxt = WIDTH'({cell_d, d_sh} >> 1);
    assign last     = (bcnt == CW'(WIDTH - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            br     <= 1'b0;
            bcnt   <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                a_sh <= a;
                b_sh <= b;
                br   <= 1'b0;
                bcnt <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                d_sh <= d_sh_nxt;
                br   <= cell_bo;
                bcnt <= bcnt + CW'(1);
                // Outputs are separate registers so they hold steady during RUN.
                if (last) begin
                    diff   <= d_sh_nxt;
                    borrow <= cell_bo;
                end
            end
        end
    end

endmodule
